// File: rtl/hub75_frame_buffer.sv
// Double/single-buffered HUB75 frame store with 2-cycle plane-select read pipeline.
// Define HUB75_FB_DOUBLE_BUFFER_EN for two buffers with a frame-synchronous swap.
module hub75_frame_buffer #(
  parameter int COLS  = 512,
  parameter int ROWS  = 64,
  parameter int RBITS = 5,
  parameter int GBITS = 6,
  parameter int BBITS = 5,
  localparam int DW   = RBITS + GBITS + BBITS,
  localparam int AW   = $clog2(COLS * ROWS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-2:0] rd_addr,
  input  logic [2:0]    rd_bit_plane,
  output logic          rd_valid,
  output logic          r0,
  output logic          g0,
  output logic          b0,
  output logic          r1,
  output logic          g1,
  output logic          b1,
  input  logic          frame_sync,
  input  logic          swap_req,
  output logic          swap_pending,
  output logic          swap_ack,
  output logic          front_buf
);

  localparam int HW  = COLS * ROWS / 2;
  localparam int HAW = AW - 1;

  typedef enum logic {IDLE, PEND} swapState_e;

  swapState_e state_q, state_d;
  logic       front_q, front_d;
  logic       ack_q, ack_d;
  logic       swapNow;

`ifdef HUB75_FB_DOUBLE_BUFFER_EN
  localparam int DEPTH = 2 * HW;
  logic [AW-1:0] wrIdx, rdIdx;
  // Writes target the back buffer; reads capture the front buffer at request time.
  assign wrIdx = {~front_q, wr_addr[HAW-1:0]};
  assign rdIdx = {front_q, rd_addr};
`else
  localparam int DEPTH = HW;
  logic [HAW-1:0] wrIdx, rdIdx;
  assign wrIdx = wr_addr[HAW-1:0];
  assign rdIdx = rd_addr;
`endif

  logic [DW-1:0] memUp [DEPTH];
  logic [DW-1:0] memLo [DEPTH];
  logic [DW-1:0] pixUp_q, pixLo_q;
  logic [2:0]    plane_q;
  logic          valid1_q;
  logic [2:0]    rgbUp_q, rgbUp_d;
  logic [2:0]    rgbLo_q, rgbLo_d;
  logic          rdValid_q, rdValid_d;

  always_comb begin
    state_d = state_q;
    swapNow = 1'b0;
    case (state_q)
      IDLE: begin
        if (swap_req && frame_sync) begin
          swapNow = 1'b1;
        end else if (swap_req) begin
          state_d = PEND;
        end
      end
      PEND: begin
        if (frame_sync) begin
          swapNow = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ack_d = swapNow;
`ifdef HUB75_FB_DOUBLE_BUFFER_EN
    front_d = front_q ^ swapNow;
`else
    front_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      front_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      ack_q   <= ack_d;
    end
  end

  // RAM has no reset so it maps onto block memory; read returns old data on a collision.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_addr[AW-1]) begin
        memLo[wrIdx] <= wr_data;
      end else begin
        memUp[wrIdx] <= wr_data;
      end
    end
    if (rd_en) begin
      pixUp_q <= memUp[rdIdx];
      pixLo_q <= memLo[rdIdx];
    end
  end

  // Each colour is left-aligned to 8 bits so plane 7 is always its MSB.
  function automatic logic [2:0] planeBits(input logic [DW-1:0] px, input logic [2:0] p);
    logic [7:0] rA, gA, bA;
    rA = 8'(px[RBITS-1:0]) << (8 - RBITS);
    gA = 8'(px[RBITS+GBITS-1:RBITS]) << (8 - GBITS);
    bA = 8'(px[DW-1:RBITS+GBITS]) << (8 - BBITS);
    return {bA[p], gA[p], rA[p]};
  endfunction

  always_comb begin
    rgbUp_d   = rgbUp_q;
    rgbLo_d   = rgbLo_q;
    rdValid_d = valid1_q;
    if (valid1_q) begin
      rgbUp_d = planeBits(pixUp_q, plane_q);
      rgbLo_d = planeBits(pixLo_q, plane_q);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      plane_q   <= 3'd0;
      valid1_q  <= 1'b0;
      rgbUp_q   <= 3'd0;
      rgbLo_q   <= 3'd0;
      rdValid_q <= 1'b0;
    end else begin
      valid1_q  <= rd_en;
      if (rd_en) begin
        plane_q <= rd_bit_plane;
      end
      rgbUp_q   <= rgbUp_d;
      rgbLo_q   <= rgbLo_d;
      rdValid_q <= rdValid_d;
    end
  end

  assign rd_valid     = rdValid_q;
  assign r0           = rgbUp_q[0];
  assign g0           = rgbUp_q[1];
  assign b0           = rgbUp_q[2];
  assign r1           = rgbLo_q[0];
  assign g1           = rgbLo_q[1];
  assign b1           = rgbLo_q[2];
  assign swap_pending = (state_q == PEND);
  assign swap_ack     = ack_q;
  assign front_buf    = front_q;

endmodule

// File: tb/tb_hub75_frame_buffer.sv
// Directed bench for hub75_frame_buffer (512x64, 5/6/5); expectations follow
// HUB75_FB_DOUBLE_BUFFER_EN when it is defined.
module tb_hub75_frame_buffer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [13:0] rd_addr;
  logic [2:0]  rd_bit_plane;
  logic        rd_valid;
  logic        r0, g0, b0, r1, g1, b1;
  logic        frame_sync;
  logic        swap_req;
  logic        swap_pending;
  logic        swap_ack;
  logic        front_buf;
  logic [5:0]  rgb;

  int   compared   = 0;
  int   mismatched = 0;
  logic expFront   = 1'b0;
  logic [5:0] latExp [0:3];
  logic [5:0] tornExp;

  always #5 clk = ~clk;

  assign rgb = {b1, g1, r1, b0, g0, r0};

  hub75_frame_buffer dut (
    .clk          (clk),
    .resetn       (resetn),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_bit_plane (rd_bit_plane),
    .rd_valid     (rd_valid),
    .r0           (r0),
    .g0           (g0),
    .b0           (b0),
    .r1           (r1),
    .g1           (g1),
    .b1           (b1),
    .frame_sync   (frame_sync),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .swap_ack     (swap_ack),
    .front_buf    (front_buf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rdEn, input logic [13:0] addr, input logic [2:0] plane,
                               input logic req, input logic sync);
    wr_en        = 1'b0;
    rd_en        = rdEn;
    rd_addr      = addr;
    rd_bit_plane = plane;
    swap_req     = req;
    frame_sync   = sync;
    tick();
  endtask

  task automatic writePixel(input logic [14:0] addr, input logic [15:0] data);
    rd_en      = 1'b0;
    swap_req   = 1'b0;
    frame_sync = 1'b0;
    wr_en      = 1'b1;
    wr_addr    = addr;
    wr_data    = data;
    tick();
    wr_en      = 1'b0;
  endtask

  // Leaves the bench two cycles after the request, when its result is visible.
  task automatic readPixel(input logic [13:0] addr, input logic [2:0] plane);
    applyStimulus(1'b1, addr, plane, 1'b0, 1'b0);
    applyStimulus(1'b0, 14'd0, plane, 1'b0, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0;
    rd_addr = '0; rd_bit_plane = '0; frame_sync = 1'b0; swap_req = 1'b0;
    latExp[0] = 6'b111001;
    latExp[1] = 6'b000010;
    latExp[2] = 6'b000100;
    latExp[3] = 6'b000111;

    repeat (3) tick();
    checkOutput("rst_valid", rd_valid, 1'b0);
    checkOutput("rst_rgb", rgb, 6'b0);
    checkOutput("rst_pending", swap_pending, 1'b0);
    checkOutput("rst_ack", swap_ack, 1'b0);
    checkOutput("rst_front", front_buf, 1'b0);
    resetn = 1'b1;
    tick();

    // Pattern lands in the back buffer (or the only buffer).
    writePixel(15'h0000, 16'hFFFF);
    writePixel(15'h4000, 16'h0000);
    writePixel(15'h0001, 16'h0010);
    writePixel(15'h0002, 16'h0400);
    writePixel(15'h0003, 16'h8000);
    writePixel(15'h0004, 16'h8410);
    writePixel(15'h4001, 16'h8410);
    writePixel(15'h4002, 16'h0000);
    writePixel(15'h4003, 16'h0000);
    writePixel(15'h4004, 16'h0000);
    writePixel(15'h0005, 16'h0010);
    writePixel(15'h4005, 16'h0000);

    // Same-cycle request and frame_sync: immediate swap, single ack.
    applyStimulus(1'b0, 14'd0, 3'd0, 1'b1, 1'b1);
`ifdef HUB75_FB_DOUBLE_BUFFER_EN
    expFront = ~expFront;
`endif
    checkOutput("race_ack", swap_ack, 1'b1);
    checkOutput("race_pending", swap_pending, 1'b0);
    checkOutput("race_front", front_buf, expFront);
    applyStimulus(1'b0, 14'd0, 3'd0, 1'b0, 1'b0);
    checkOutput("race_ack_once", swap_ack, 1'b0);

    for (int p = 7; p >= 0; p--) begin
      readPixel(14'd0, 3'(p));
      checkOutput("plane_valid", rd_valid, 1'b1);
      checkOutput($sformatf("plane%0d", p), rgb,
                  {3'b000, (p >= 3) ? 1'b1 : 1'b0, (p >= 2) ? 1'b1 : 1'b0, (p >= 3) ? 1'b1 : 1'b0});
    end

    for (int i = 0; i < 7; i++) begin
      if (i < 4) applyStimulus(1'b1, 14'(i + 1), 3'd7, 1'b0, 1'b0);
      else       applyStimulus(1'b0, 14'd0, 3'd7, 1'b0, 1'b0);
      checkOutput($sformatf("lat_valid_n%0d", i + 1), rd_valid, (i >= 1 && i <= 4) ? 1'b1 : 1'b0);
      if (i >= 1 && i <= 4) checkOutput($sformatf("lat_data_n%0d", i + 1), rgb, latExp[i-1]);
      else if (i > 4)       checkOutput("lat_hold", rgb, latExp[3]);
    end

    // New pattern for addr 5 goes to the back buffer, then a delayed swap with a torn-read probe.
    writePixel(15'h0005, 16'h8410);
`ifdef HUB75_FB_DOUBLE_BUFFER_EN
    tornExp = 6'b000001;
`else
    tornExp = 6'b000111;
`endif
    applyStimulus(1'b0, 14'd0, 3'd7, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      checkOutput($sformatf("swap_pending_c%0d", i), swap_pending, 1'b1);
      checkOutput("swap_no_early_ack", swap_ack, 1'b0);
      if (i == 10) applyStimulus(1'b1, 14'd5, 3'd7, 1'b0, 1'b1);
      else         applyStimulus(1'b0, 14'd0, 3'd7, 1'b0, 1'b0);
    end
`ifdef HUB75_FB_DOUBLE_BUFFER_EN
    expFront = ~expFront;
`endif
    checkOutput("swap_pending_drop", swap_pending, 1'b0);
    checkOutput("swap_ack", swap_ack, 1'b1);
    checkOutput("swap_front", front_buf, expFront);
    applyStimulus(1'b0, 14'd0, 3'd7, 1'b0, 1'b0);
    checkOutput("swap_ack_once", swap_ack, 1'b0);
    checkOutput("torn_valid", rd_valid, 1'b1);
    checkOutput("torn_data", rgb, tornExp);
    readPixel(14'd5, 3'd7);
    checkOutput("swap_new_data", rgb, 6'b000111);

    // Second request while pending is absorbed.
    applyStimulus(1'b0, 14'd0, 3'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 14'd0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 14'd0, 3'd0, 1'b1, 1'b0);
    checkOutput("dbl_pending", swap_pending, 1'b1);
    applyStimulus(1'b0, 14'd0, 3'd0, 1'b0, 1'b1);
`ifdef HUB75_FB_DOUBLE_BUFFER_EN
    expFront = ~expFront;
`endif
    checkOutput("dbl_ack", swap_ack, 1'b1);
    checkOutput("dbl_pending_drop", swap_pending, 1'b0);
    checkOutput("dbl_front", front_buf, expFront);
    applyStimulus(1'b0, 14'd0, 3'd0, 1'b0, 1'b1);
    checkOutput("dbl_no_second_ack", swap_ack, 1'b0);
    checkOutput("dbl_front_once", front_buf, expFront);

    // Reset while pending drops the swap.
    applyStimulus(1'b0, 14'd0, 3'd0, 1'b1, 1'b0);
    checkOutput("rstp_pending", swap_pending, 1'b1);
    resetn = 1'b0;
    #1;
    expFront = 1'b0;
    checkOutput("rstp_pending_clr", swap_pending, 1'b0);
    checkOutput("rstp_front", front_buf, expFront);
    tick();
    resetn = 1'b1;
    applyStimulus(1'b0, 14'd0, 3'd0, 1'b0, 1'b1);
    checkOutput("rstp_no_ack", swap_ack, 1'b0);
    applyStimulus(1'b0, 14'd0, 3'd0, 1'b0, 1'b0);
    checkOutput("rstp_no_ack2", swap_ack, 1'b0);
    checkOutput("rstp_front2", front_buf, expFront);

    // Write then read back (single buffer needs no swap).
    writePixel(15'h0007, 16'h8410);
    writePixel(15'h4007, 16'h0400);
`ifdef HUB75_FB_DOUBLE_BUFFER_EN
    applyStimulus(1'b0, 14'd0, 3'd0, 1'b1, 1'b1);
    expFront = ~expFront;
`endif
    readPixel(14'd7, 3'd7);
    checkOutput("wb_valid", rd_valid, 1'b1);
    checkOutput("wb_data", rgb, 6'b010111);
    checkOutput("wb_front", front_buf, expFront);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
